// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Walks each instruction through fetch, decode, execute, memory and
// writeback. Control outputs are decoded combinationally from the current
// state and the IR fields. They are forced to zero while reset is asserted,
// so an abort never leaves a write enable active.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       mem_we,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MW    = 4'd4,
    S_WB_LD = 4'd5,
    S_EX_R  = 4'd6,
    S_WB_R  = 4'd7,
    S_EX_I  = 4'd8,
    S_WB_I  = 4'd9,
    S_BR    = 4'd10,
    S_JMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  state_e state_q, state_d;

  logic is_r, r_alu, r_jr;

  // Instruction class decode shared by next-state and output logic
  always_comb begin
    is_r  = (opcode == OP_R);
    r_jr  = is_r && (funct == FN_JR);
    r_alu = is_r && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                     (funct == FN_AND)  || (funct == FN_OR)   ||
                     (funct == FN_SLT));
  end

  // Next-state selection; unknown codes fall back to fetch
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if ((opcode == OP_J) || (opcode == OP_JAL) || r_jr)   state_d = S_JMP;
        else if (opcode == OP_BEQ)                            state_d = S_BR;
        else if ((opcode == OP_LW) || (opcode == OP_SW))      state_d = S_MA;
        else if (r_alu)                                       state_d = S_EX_R;
        else if ((opcode == OP_ADDIU) || (opcode == OP_ORI) ||
                 (opcode == OP_LUI))                          state_d = S_EX_I;
        else                                                  state_d = S_IF;
      end
      S_MA:   state_d = (opcode == OP_LW) ? S_MR : S_MW;
      S_MR:   state_d = S_WB_LD;
      S_EX_R: state_d = S_WB_R;
      S_EX_I: state_d = S_WB_I;
      default: state_d = S_IF;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= state_e'(RESET_STATE);
    else      state_q <= state_d;
  end

  // Per-state control decode, gated to zero during reset
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    mem_we     = 1'b0;
    alu_srca   = 1'b0;
    alu_srcb   = 2'd0;
    alu_op     = ALU_ADD;
    ext_op     = 2'd0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    pc_src     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = state_q;
    case (state_q)
      S_IF: begin
        ir_we    = 1'b1;
        pc_we    = 1'b1;
        alu_srcb = 2'd1;
      end
      S_ID: begin
        // Speculatively form the branch target into ALUOut
        alu_srcb = 2'd3;
        ext_op   = 2'd1;
        if (!((opcode == OP_J) || (opcode == OP_JAL) || r_jr || r_alu ||
              (opcode == OP_BEQ) || (opcode == OP_LW) || (opcode == OP_SW) ||
              (opcode == OP_ADDIU) || (opcode == OP_ORI) || (opcode == OP_LUI))) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MA: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
        ext_op   = 2'd1;
      end
      S_MW: begin
        mem_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_LD: begin
        rf_we      = 1'b1;
        wd_sel     = 2'd1;
        instr_done = 1'b1;
      end
      S_EX_R: begin
        alu_srca = 1'b1;
        case (funct)
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        rf_we      = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
      end
      S_EX_I: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
        case (opcode)
          OP_ORI:  begin alu_op = ALU_OR;  ext_op = 2'd0; end
          OP_LUI:  begin alu_op = ALU_LUI; ext_op = 2'd0; end
          default: begin alu_op = ALU_ADD; ext_op = 2'd1; end
        endcase
      end
      S_WB_I: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_BR: begin
        alu_srca   = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_we      = zero;
        instr_done = 1'b1;
      end
      S_JMP: begin
        pc_we      = 1'b1;
        instr_done = 1'b1;
        if (r_jr) begin
          pc_src = 2'd3;
        end else begin
          pc_src = 2'd2;
          // jal links the already-incremented PC into $31
          if (opcode == OP_JAL) begin
            rf_we   = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
        end
      end
      default: ;
    endcase
    if (!rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      rf_we      = 1'b0;
      mem_we     = 1'b0;
      alu_srca   = 1'b0;
      alu_srcb   = 2'd0;
      alu_op     = ALU_ADD;
      ext_op     = 2'd0;
      reg_dst    = 2'd0;
      wd_sel     = 2'd0;
      pc_src     = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      state      = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes a hand-written
// expected control vector for every cycle it drives, and a negedge monitor
// pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_we, ir_we, rf_we, mem_we, alu_srca;
  logic [1:0] alu_srcb, ext_op, reg_dst, wd_sel, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       instr_done, illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_we(mem_we),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .ext_op(ext_op), .reg_dst(reg_dst), .wd_sel(wd_sel), .pc_src(pc_src),
    .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] vec;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [23:0] act;
  assign act = {state, pc_we, ir_we, rf_we, mem_we, alu_srca, alu_srcb,
                alu_op, ext_op, reg_dst, wd_sel, pc_src, instr_done, illegal};

  // Field order: state pc_we ir_we rf_we mem_we srca srcb op ext rdst wdsel pcsrc done ill
  function automatic logic [23:0] v(input int st, input int pw, input int iw,
      input int rw, input int mw, input int sa, input int sb, input int op,
      input int ex, input int rd, input int wd, input int ps, input int dn,
      input int il);
    logic [3:0] s4; logic [1:0] b2, e2, r2, w2, p2; logic [2:0] o3;
    s4 = st[3:0]; b2 = sb[1:0]; o3 = op[2:0]; e2 = ex[1:0];
    r2 = rd[1:0]; w2 = wd[1:0]; p2 = ps[1:0];
    return {s4, pw[0], iw[0], rw[0], mw[0], sa[0], b2, o3, e2, r2, w2, p2,
            dn[0], il[0]};
  endfunction

  logic [23:0] ZERO, IFV, IDV, IDILL, MAV, MRV, MWV, WBLD, WBR, WBI;
  initial begin
    ZERO  = v(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
    IFV   = v(0, 1,1,0,0, 0,1,0,0, 0,0,0, 0,0);
    IDV   = v(1, 0,0,0,0, 0,3,0,1, 0,0,0, 0,0);
    IDILL = v(1, 0,0,0,0, 0,3,0,1, 0,0,0, 1,1);
    MAV   = v(2, 0,0,0,0, 1,2,0,1, 0,0,0, 0,0);
    MRV   = v(3, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
    MWV   = v(4, 0,0,0,1, 0,0,0,0, 0,0,0, 1,0);
    WBLD  = v(5, 0,0,1,0, 0,0,0,0, 0,1,0, 1,0);
    WBR   = v(7, 0,0,1,0, 0,0,0,0, 1,0,0, 1,0);
    WBI   = v(9, 0,0,1,0, 0,0,0,0, 0,0,0, 1,0);
  end

  // Monitor: compare one expected vector per cycle, mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL %s: got %h (state %0d) expected %h", e.name, act,
                 act[23:20], e.vec);
      end
    end
  end

  task automatic step(input string nm, input logic [23:0] e);
    exp_t x;
    x.name = nm; x.vec = e;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  // Runs IF, ID and up to three follow-on states of one instruction
  task automatic do_instr(input string nm, input logic [5:0] opc,
      input logic [5:0] fn, input logic z, input logic [23:0] idrow,
      input int n, input logic [23:0] r2, input logic [23:0] r3,
      input logic [23:0] r4);
    opcode = opc; funct = fn; zero = z;
    step({nm, "/IF"}, IFV);
    step({nm, "/ID"}, idrow);
    if (n > 0) step({nm, "/s2"}, r2);
    if (n > 1) step({nm, "/s3"}, r3);
    if (n > 2) step({nm, "/s4"}, r4);
  endtask

  initial begin
    rst = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset0", ZERO);
    step("reset1", ZERO);
    step("reset2", ZERO);
    rst = 1'b1;

    do_instr("addu", 6'b000000, 6'b100001, 0, IDV, 2,
             v(6, 0,0,0,0, 1,0,0,0, 0,0,0, 0,0), WBR, ZERO);
    do_instr("subu", 6'b000000, 6'b100011, 0, IDV, 2,
             v(6, 0,0,0,0, 1,0,1,0, 0,0,0, 0,0), WBR, ZERO);
    do_instr("and",  6'b000000, 6'b100100, 0, IDV, 2,
             v(6, 0,0,0,0, 1,0,3,0, 0,0,0, 0,0), WBR, ZERO);
    do_instr("or",   6'b000000, 6'b100101, 0, IDV, 2,
             v(6, 0,0,0,0, 1,0,2,0, 0,0,0, 0,0), WBR, ZERO);
    do_instr("slt",  6'b000000, 6'b101010, 0, IDV, 2,
             v(6, 0,0,0,0, 1,0,4,0, 0,0,0, 0,0), WBR, ZERO);
    do_instr("lw",   6'b100011, 6'b000000, 0, IDV, 3, MAV, MRV, WBLD);
    do_instr("sw",   6'b101011, 6'b000000, 0, IDV, 2, MAV, MWV, ZERO);
    do_instr("beq_t",6'b000100, 6'b000000, 1, IDV, 1,
             v(10, 1,0,0,0, 1,0,1,0, 0,0,1, 1,0), ZERO, ZERO);
    do_instr("beq_n",6'b000100, 6'b000000, 0, IDV, 1,
             v(10, 0,0,0,0, 1,0,1,0, 0,0,1, 1,0), ZERO, ZERO);
    do_instr("jal",  6'b000011, 6'b000000, 0, IDV, 1,
             v(11, 1,0,1,0, 0,0,0,0, 2,2,2, 1,0), ZERO, ZERO);
    do_instr("j",    6'b000010, 6'b000000, 0, IDV, 1,
             v(11, 1,0,0,0, 0,0,0,0, 0,0,2, 1,0), ZERO, ZERO);
    do_instr("jr",   6'b000000, 6'b001000, 0, IDV, 1,
             v(11, 1,0,0,0, 0,0,0,0, 0,0,3, 1,0), ZERO, ZERO);
    do_instr("addiu",6'b001001, 6'b000000, 0, IDV, 2,
             v(8, 0,0,0,0, 1,2,0,1, 0,0,0, 0,0), WBI, ZERO);
    do_instr("ori",  6'b001101, 6'b000000, 0, IDV, 2,
             v(8, 0,0,0,0, 1,2,2,0, 0,0,0, 0,0), WBI, ZERO);
    do_instr("lui",  6'b001111, 6'b000000, 0, IDV, 2,
             v(8, 0,0,0,0, 1,2,5,0, 0,0,0, 0,0), WBI, ZERO);
    do_instr("ill_op", 6'b111111, 6'b000000, 0, IDILL, 0, ZERO, ZERO, ZERO);
    do_instr("ill_fn", 6'b000000, 6'b000000, 0, IDILL, 0, ZERO, ZERO, ZERO);

    // Reset asserted in the middle of MW must kill mem_we at once
    opcode = 6'b101011; funct = 6'd0;
    step("swab/IF", IFV);
    step("swab/ID", IDV);
    step("swab/MA", MAV);
    begin
      exp_t x;
      x.name = "swab/MW"; x.vec = MWV;
      q.push_back(x);
    end
    #6;
    rst = 1'b0;
    #1;
    n_tests++;
    if (act !== ZERO) begin
      n_fail++;
      $display("FAIL swab/abort: got %h expected %h", act, ZERO);
    end
    @(posedge clk); #1;
    step("swab/hold", ZERO);
    rst = 1'b1;
    do_instr("addu2", 6'b000000, 6'b100001, 0, IDV, 2,
             v(6, 0,0,0,0, 1,0,0,0, 0,0,0, 0,0), WBR, ZERO);
    step("post/IF", IFV);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
